// File: rtl/sobel_edge_ex.sv
// Four-stage Sobel edge stage: gradient sums, absolute differences, magnitude/threshold,
// mode-selected output. Threshold and mode are shadowed per frame; edge pixels are counted per frame.
module sobel_edge_ex #(
   parameter int DW        = 8,
   parameter int MAG_SHIFT = 2,
   parameter int THR_INIT  = 28,
   parameter int CNT_W     = 22
) (
   input  logic             video_clk,
   input  logic             rst_n,
   input  logic [DW+2:0]    sobel_threshold,
   input  logic [1:0]       sobel_mode,
   input  logic             matrix_de,
   input  logic             matrix_vs,
   input  logic [DW-1:0]    matrix11,
   input  logic [DW-1:0]    matrix12,
   input  logic [DW-1:0]    matrix13,
   input  logic [DW-1:0]    matrix21,
   input  logic [DW-1:0]    matrix22,
   input  logic [DW-1:0]    matrix23,
   input  logic [DW-1:0]    matrix31,
   input  logic [DW-1:0]    matrix32,
   input  logic [DW-1:0]    matrix33,
   output logic             sobel_vs,
   output logic             sobel_de,
   output logic [DW-1:0]    sobel_data,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             edge_cnt_valid
);

   localparam int SW      = DW + 2;
   localparam int LW      = DW + 3;
   localparam int PIX_MAX = (1 << DW) - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SW-1:0]    gx1_reg, gx2_reg, gy1_reg, gy2_reg;
   logic [SW-1:0]    gx1_next, gx2_next, gy1_next, gy2_next;
   logic [SW-1:0]    gx_reg, gy_reg;
   logic [LW-1:0]    l1_reg, l1_next;
   logic [SW-1:0]    linf_reg;
   logic             hit_reg, hit_s4_reg;
   logic [DW-1:0]    data_reg, data_next;
   logic [3:0]       de_pipe_reg, vs_pipe_reg;
   logic             vs_rise_reg;
   logic [LW-1:0]    thr_sh_reg;
   logic [1:0]       mode_sh_reg;
   logic [CNT_W-1:0] acc_reg, edge_cnt_reg;
   logic             edge_valid_reg;
   logic             count_hit, frame_edge;
   logic [LW-1:0]    l1_shift;
   logic [SW-1:0]    linf_shift;
   logic [DW-1:0]    l1_sat, linf_sat;
   logic             unused_centre;

   // The centre tap carries no weight in either Sobel kernel.
   assign unused_centre = &{1'b0, matrix22};

   assign gx1_next = SW'(matrix13) + (SW'(matrix23) << 1) + SW'(matrix33);
   assign gx2_next = SW'(matrix11) + (SW'(matrix21) << 1) + SW'(matrix31);
   assign gy1_next = SW'(matrix11) + (SW'(matrix12) << 1) + SW'(matrix13);
   assign gy2_next = SW'(matrix31) + (SW'(matrix32) << 1) + SW'(matrix33);
   assign l1_next  = LW'(gx_reg) + LW'(gy_reg);

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         gx1_reg <= '0;
         gx2_reg <= '0;
         gy1_reg <= '0;
         gy2_reg <= '0;
      end else if (matrix_de) begin
         gx1_reg <= gx1_next;
         gx2_reg <= gx2_next;
         gy1_reg <= gy1_next;
         gy2_reg <= gy2_next;
      end else begin
         gx1_reg <= '0;
         gx2_reg <= '0;
         gy1_reg <= '0;
         gy2_reg <= '0;
      end
   end

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         gx_reg     <= '0;
         gy_reg     <= '0;
         l1_reg     <= '0;
         linf_reg   <= '0;
         hit_reg    <= 1'b0;
         hit_s4_reg <= 1'b0;
         data_reg   <= '0;
      end else begin
         gx_reg     <= (gx1_reg >= gx2_reg) ? gx1_reg - gx2_reg : gx2_reg - gx1_reg;
         gy_reg     <= (gy1_reg >= gy2_reg) ? gy1_reg - gy2_reg : gy2_reg - gy1_reg;
         l1_reg     <= l1_next;
         linf_reg   <= (gx_reg >= gy_reg) ? gx_reg : gy_reg;
         hit_reg    <= (l1_next >= thr_sh_reg);
         hit_s4_reg <= hit_reg;
         data_reg   <= data_next;
      end
   end

   assign l1_shift   = l1_reg >> MAG_SHIFT;
   assign linf_shift = linf_reg >> MAG_SHIFT;
   assign l1_sat     = (l1_shift > LW'(PIX_MAX)) ? '1 : l1_shift[DW-1:0];
   assign linf_sat   = (linf_shift > SW'(PIX_MAX)) ? '1 : linf_shift[DW-1:0];

   always_comb begin
      data_next = '0;
      if (de_pipe_reg[2]) begin
         case (mode_sh_reg)
            2'd0:    data_next = hit_reg ? '1 : '0;
            2'd1:    data_next = hit_reg ? '0 : '1;
            2'd2:    data_next = l1_sat;
            default: data_next = linf_sat;
         endcase
      end
   end

   // Shadows load one cycle after the input vs rise, while the pipeline is still in blanking.
   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         de_pipe_reg <= '0;
         vs_pipe_reg <= '0;
         vs_rise_reg <= 1'b0;
         thr_sh_reg  <= LW'(THR_INIT);
         mode_sh_reg <= 2'd0;
      end else begin
         de_pipe_reg <= {de_pipe_reg[2:0], matrix_de};
         vs_pipe_reg <= {vs_pipe_reg[2:0], matrix_vs};
         vs_rise_reg <= matrix_vs & ~vs_pipe_reg[0];
         if (vs_rise_reg) begin
            thr_sh_reg  <= sobel_threshold;
            mode_sh_reg <= sobel_mode;
         end
      end
   end

   assign count_hit  = de_pipe_reg[3] & hit_s4_reg;
   assign frame_edge = vs_pipe_reg[2] & ~vs_pipe_reg[3];

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg        <= '0;
         edge_cnt_reg   <= '0;
         edge_valid_reg <= 1'b0;
      end else begin
         edge_valid_reg <= frame_edge;
         if (frame_edge) begin
            edge_cnt_reg <= acc_reg;
            acc_reg      <= count_hit ? CNT_W'(1) : '0;
         end else if (count_hit && acc_reg != CNT_MAX) begin
            acc_reg <= acc_reg + CNT_W'(1);
         end
      end
   end

   assign sobel_vs       = vs_pipe_reg[3];
   assign sobel_de       = de_pipe_reg[3];
   assign sobel_data     = data_reg;
   assign edge_cnt       = edge_cnt_reg;
   assign edge_cnt_valid = edge_valid_reg;

endmodule

// File: tb/tb_sobel_edge_ex.sv
// Directed bench for sobel_edge_ex: output modes, de gating, frame shadowing,
// per-frame edge counting and mid-frame reset.
module tb_sobel_edge_ex;

   logic        video_clk = 1'b0;
   logic        rst_n;
   logic [10:0] sobel_threshold;
   logic [1:0]  sobel_mode;
   logic        matrix_de, matrix_vs;
   logic [7:0]  matrix11, matrix12, matrix13;
   logic [7:0]  matrix21, matrix22, matrix23;
   logic [7:0]  matrix31, matrix32, matrix33;
   logic        sobel_vs, sobel_de;
   logic [7:0]  sobel_data;
   logic [21:0] edge_cnt;
   logic        edge_cnt_valid;

   int checks = 0;
   int errors = 0;

   sobel_edge_ex dut (
      .video_clk      (video_clk),
      .rst_n          (rst_n),
      .sobel_threshold(sobel_threshold),
      .sobel_mode     (sobel_mode),
      .matrix_de      (matrix_de),
      .matrix_vs      (matrix_vs),
      .matrix11       (matrix11),
      .matrix12       (matrix12),
      .matrix13       (matrix13),
      .matrix21       (matrix21),
      .matrix22       (matrix22),
      .matrix23       (matrix23),
      .matrix31       (matrix31),
      .matrix32       (matrix32),
      .matrix33       (matrix33),
      .sobel_vs       (sobel_vs),
      .sobel_de       (sobel_de),
      .sobel_data     (sobel_data),
      .edge_cnt       (edge_cnt),
      .edge_cnt_valid (edge_cnt_valid)
   );

   always #5 video_clk = ~video_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_win(input logic [7:0] a, b, c, d, e, f, g, h, i);
      matrix11 = a; matrix12 = b; matrix13 = c;
      matrix21 = d; matrix22 = e; matrix23 = f;
      matrix31 = g; matrix32 = h; matrix33 = i;
   endtask

   // One pixel with de=1, output checked 4 edges later, then the following de=0 slot.
   task automatic check_pix(input string tag, input logic [7:0] exp);
      @(negedge video_clk); matrix_de = 1'b1;
      @(negedge video_clk); matrix_de = 1'b0;
      repeat (3) @(posedge video_clk);
      #1;
      chk({tag, "_de"}, 32'(sobel_de), 32'd1);
      chk({tag, "_data"}, 32'(sobel_data), 32'(exp));
      $display("pixel %s: data=%0d expected=%0d", tag, sobel_data, exp);
      @(posedge video_clk);
      #1;
      chk({tag, "_idle"}, 32'(sobel_data), 32'd0);
   endtask

   // Vs pulse carrying new threshold/mode; checks the edge-count report of the closing frame.
   task automatic frame_start(input string tag, input logic [10:0] thr, input logic [1:0] mode,
                              input int exp_cnt);
      int          pulses;
      logic [31:0] cnt;
      logic        vs_at_pulse;
      pulses = 0; cnt = 0; vs_at_pulse = 1'b0;
      @(negedge video_clk);
      sobel_threshold = thr; sobel_mode = mode; matrix_vs = 1'b1; matrix_de = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge video_clk);
         if (i == 1) matrix_vs = 1'b0;
         if (edge_cnt_valid) begin
            pulses++;
            cnt = 32'(edge_cnt);
            vs_at_pulse = sobel_vs;
         end
      end
      chk({tag, "_pulses"}, 32'(pulses), 32'd1);
      chk({tag, "_cnt"}, cnt, 32'(exp_cnt));
      chk({tag, "_vs"}, 32'(vs_at_pulse), 32'd1);
      $display("frame %s: pulses=%0d edge_cnt=%0d expected=%0d", tag, pulses, cnt, exp_cnt);
   endtask

   initial begin
      rst_n = 1'b1;
      sobel_threshold = 11'd2000;
      sobel_mode = 2'd2;
      matrix_de = 1'b0;
      matrix_vs = 1'b0;
      set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge video_clk);
      chk("rst_data", 32'(sobel_data), 32'd0);
      chk("rst_de", 32'(sobel_de), 32'd0);
      chk("rst_vs", 32'(sobel_vs), 32'd0);
      chk("rst_cnt", 32'(edge_cnt), 32'd0);
      chk("rst_valid", 32'(edge_cnt_valid), 32'd0);
      rst_n = 1'b1;

      // Reset shadows: mode 0, threshold 28 (inputs hold 2000 / mode 2 unloaded)
      set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
      check_pix("t1_edge", 8'd255);
      set_win(100, 100, 100, 100, 100, 100, 100, 100, 100);
      check_pix("t1_flat", 8'd0);

      // L1 magnitude
      frame_start("f_mode2", 11'd28, 2'd2, 1);
      set_win(0, 0, 40, 0, 0, 40, 0, 0, 40);
      check_pix("t2_l1_160", 8'd40);
      set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
      check_pix("t2_l1_1020", 8'd255);
      set_win(0, 255, 255, 0, 0, 255, 0, 0, 255);
      check_pix("t2_l1_sat", 8'd255);

      // L-inf magnitude: gx=160, gy=80
      frame_start("f_mode3", 11'd28, 2'd3, 3);
      set_win(0, 40, 40, 0, 0, 40, 0, 0, 40);
      check_pix("t2_linf", 8'd40);

      // Inverted binary
      frame_start("f_mode1_thr0", 11'd0, 2'd1, 1);
      set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
      check_pix("t3_thr0_edge", 8'd0);
      frame_start("f_mode1_thr28", 11'd28, 2'd1, 1);
      set_win(100, 100, 100, 100, 100, 100, 100, 100, 100);
      check_pix("t3_flat_a", 8'd255);
      check_pix("t3_flat_b", 8'd255);

      // Mid-frame threshold change is ignored until next vs rise
      frame_start("f_thr28", 11'd28, 2'd0, 0);
      sobel_threshold = 11'd2000;
      set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
      check_pix("t4_still28", 8'd255);
      frame_start("f_thr2000", 11'd2000, 2'd0, 1);
      check_pix("t4_thr2000", 8'd0);

      // 10 edge + 90 flat pixels, back to back
      frame_start("f_count", 11'd28, 2'd0, 0);
      @(negedge video_clk);
      set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
      matrix_de = 1'b1;
      repeat (10) @(negedge video_clk);
      set_win(100, 100, 100, 100, 100, 100, 100, 100, 100);
      repeat (90) @(negedge video_clk);
      matrix_de = 1'b0;
      repeat (6) @(negedge video_clk);
      frame_start("f_report10", 11'd500, 2'd2, 10);

      // Mid-frame reset with thr_sh=500, edge_cnt=10 and pixels in flight
      set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
      matrix_de = 1'b1;
      repeat (6) @(negedge video_clk);
      chk("t6_pre_data", 32'(sobel_data), 32'd255);
      chk("t6_pre_de", 32'(sobel_de), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_data", 32'(sobel_data), 32'd0);
      chk("t6_rst_de", 32'(sobel_de), 32'd0);
      chk("t6_rst_cnt", 32'(edge_cnt), 32'd0);
      chk("t6_rst_valid", 32'(edge_cnt_valid), 32'd0);
      chk("t6_rst_thr", 32'(dut.thr_sh_reg), 32'd28);
      $display("reset: data=%0d de=%0d edge_cnt=%0d thr_sh=%0d", sobel_data, sobel_de, edge_cnt,
               dut.thr_sh_reg);
      repeat (3) @(negedge video_clk);
      rst_n = 1'b1;
      matrix_de = 1'b0;
      repeat (5) @(negedge video_clk);
      frame_start("f_after_rst", 11'd28, 2'd0, 0);

      // All-flat frame reports zero
      @(negedge video_clk);
      set_win(100, 100, 100, 100, 100, 100, 100, 100, 100);
      matrix_de = 1'b1;
      repeat (20) @(negedge video_clk);
      matrix_de = 1'b0;
      repeat (6) @(negedge video_clk);
      frame_start("f_flat", 11'd28, 2'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
